// File: rtl/cv_bank_mapper.sv
// Cartridge banking unit for ColecoVision / SG-1000 class carts: linear, MegaCart and
// Sega 3-slot page selection, SGM BIOS/RAM control ports and a cartridge wait-state generator.
module cv_bank_mapper #(
    parameter int PAGE_W    = 6,
    parameter int CART_WAIT = 0,
    parameter bit SGM_EN    = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [1:0]        mode_i,
    input  logic [PAGE_W-1:0] cart_pages_i,
    input  logic [15:0]       a_i,
    input  logic [7:0]        d_i,
    input  logic              mreq_n_i,
    input  logic              iorq_n_i,
    input  logic              rd_n_i,
    input  logic              wr_n_i,
    input  logic              rfsh_n_i,
    output logic [PAGE_W-1:0] cart_page_o,
    output logic [PAGE_W+13:0] rom_a_o,
    output logic              bios_en_o,
    output logic              sgm_ram_en_o,
    output logic              mapper_wr_o,
    output logic              wait_n_o
);
    localparam logic [1:0] MODE_MEGA = 2'd1;
    localparam logic [1:0] MODE_SEGA = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(CART_WAIT - 1);

    logic [PAGE_W-1:0] megacart_pg_q, megacart_pg_d;
    logic [PAGE_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d, slot2_q, slot2_d;
    logic              bios_en_q, bios_en_d, sgm_ram_en_q, sgm_ram_en_d;
    logic              mapper_wr_q, mapper_wr_d, wait_n_q, wait_n_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              mq_q, iw_q;
    logic              mq, iw, mq_first, iw_first, mega_ld, sega_ld, in_cart;
    logic              unused_bits;

    assign unused_bits = ^{d_i, a_i};

    // Bus qualification; registers only load on the first cycle of a strobe.
    assign mq       = !mreq_n_i && rfsh_n_i && (!rd_n_i || !wr_n_i);
    assign iw       = !iorq_n_i && mreq_n_i && !wr_n_i;
    assign mq_first = mq && !mq_q;
    assign iw_first = iw && !iw_q;

    assign mega_ld = mq_first && !rd_n_i && (mode_i == MODE_MEGA) && (a_i[15:6] == 10'h3FF);
    assign sega_ld = mq_first && !wr_n_i && (mode_i == MODE_SEGA) && (a_i[15:2] == 14'h3FFF)
                     && (a_i[1:0] != 2'b00);
    assign in_cart = (mode_i == MODE_SEGA) ? (a_i[15:14] != 2'b11) : a_i[15];

    always_comb begin
        cart_page_o = '0;
        case (mode_i)
            MODE_MEGA: begin
                if (a_i[15:14] == 2'b10) cart_page_o = cart_pages_i;
                else if (a_i[15:14] == 2'b11) cart_page_o = megacart_pg_q;
            end
            MODE_SEGA: begin
                case (a_i[15:14])
                    2'b00:   cart_page_o = slot0_q;
                    2'b01:   cart_page_o = slot1_q;
                    2'b10:   cart_page_o = slot2_q;
                    default: cart_page_o = '0;
                endcase
            end
            default: begin
                if (a_i[15:14] == 2'b11) cart_page_o = PAGE_W'(1) & cart_pages_i;
            end
        endcase
    end

    assign rom_a_o = {cart_page_o, a_i[13:0]};

    always_comb begin
        megacart_pg_d = megacart_pg_q;
        slot0_d       = slot0_q;
        slot1_d       = slot1_q;
        slot2_d       = slot2_q;
        bios_en_d     = bios_en_q;
        sgm_ram_en_d  = sgm_ram_en_q;
        wait_n_d      = wait_n_q;
        wait_cnt_d    = wait_cnt_q;
        mapper_wr_d   = mega_ld || sega_ld;

        if (mega_ld) megacart_pg_d = a_i[PAGE_W-1:0] & cart_pages_i;
        if (sega_ld) begin
            case (a_i[1:0])
                2'b01:   slot0_d = d_i[PAGE_W-1:0] & cart_pages_i;
                2'b10:   slot1_d = d_i[PAGE_W-1:0] & cart_pages_i;
                default: slot2_d = d_i[PAGE_W-1:0] & cart_pages_i;
            endcase
        end

        if (iw_first && a_i[7:0] == 8'h7F) bios_en_d = d_i[1];
        if (mode_i == MODE_SEGA) bios_en_d = 1'b0;
        if (SGM_EN && iw_first && a_i[7:0] == 8'h53) sgm_ram_en_d = d_i[0];

        // Count down while WAIT is held low; release on the edge after the counter hits zero.
        if (!wait_n_q) begin
            if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
            else                    wait_n_d   = 1'b1;
        end else if ((CART_WAIT > 0) && mq_first && in_cart) begin
            wait_n_d   = 1'b0;
            wait_cnt_d = WAIT_INIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            megacart_pg_q <= '0;
            slot0_q       <= '0;
            slot1_q       <= PAGE_W'(1) & cart_pages_i;
            slot2_q       <= PAGE_W'(2) & cart_pages_i;
            bios_en_q     <= 1'b1;
            sgm_ram_en_q  <= 1'b0;
            mapper_wr_q   <= 1'b0;
            wait_n_q      <= 1'b1;
            wait_cnt_q    <= 4'd0;
            mq_q          <= 1'b0;
            iw_q          <= 1'b0;
        end else begin
            megacart_pg_q <= megacart_pg_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            slot2_q       <= slot2_d;
            bios_en_q     <= bios_en_d;
            sgm_ram_en_q  <= sgm_ram_en_d;
            mapper_wr_q   <= mapper_wr_d;
            wait_n_q      <= wait_n_d;
            wait_cnt_q    <= wait_cnt_d;
            mq_q          <= mq;
            iw_q          <= iw;
        end
    end

    assign bios_en_o    = bios_en_q;
    assign sgm_ram_en_o = sgm_ram_en_q;
    assign mapper_wr_o  = mapper_wr_q;
    assign wait_n_o     = wait_n_q;
endmodule

// File: doc/cv_bank_mapper.md
Name: cv_bank_mapper

Overview:
- Parametrised cartridge banking unit that replaces fixed cartridge paging, for ColecoVision and SG-1000 class cartridges.
- Supports linear, MegaCart and Sega-style 3-slot mappers, plus Super Game Module (SGM) BIOS/RAM control registers and a programmable cartridge wait-state generator.
- Sits between the Z80 bus and the cartridge ROM/SDRAM address path, alongside the chip-select decoder.

Parameters:
- PAGE_W, 6, width of 16 KB page number; legal range 1..6 (up to 1 MB).
- CART_WAIT, 0, wait cycles inserted per cartridge access; 0..15; 0 disables.
- SGM_EN, 1, 1 = port 0x53 RAM-enable register implemented; 0 = sgm_ram_en_o tied 0.

Ports:
- clk_i in 1: system clock.
- reset_n_i in 1: reset. One clock; reset is synchronous and active-low.
- mode_i in 2: 0 = LINEAR, 1 = MEGACART, 2 = SEGA, 3 = reserved (treated as LINEAR).
- cart_pages_i in PAGE_W: page mask = page count - 1.
- a_i in 16: Z80 address.
- d_i in 8: Z80 write data.
- mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, rfsh_n_i in 1 each: Z80 strobes, active low.
- cart_page_o out PAGE_W: selected page for the current address.
- rom_a_o out PAGE_W+14: {cart_page_o, a_i[13:0]}.
- bios_en_o out 1: BIOS mapped at 0000-1FFF.
- sgm_ram_en_o out 1: SGM lower RAM enabled.
- mapper_wr_o out 1: one-cycle pulse on any bank-register update.
- wait_n_o out 1: Z80 WAIT, active low.

Behaviour:
- Reset values (next clk_i edge with reset_n_i=0):
  - megacart_pg=0; slot0/1/2 = 0/1/2 & cart_pages_i.
  - bios_en_o=1; sgm_ram_en_o=0; mapper_wr_o=0; wait_n_o=1; wait counter=0.
  - Edge-detect flags = 0.
- Qualified mem access (mq): mreq_n_i=0 & rfsh_n_i=1 & (rd_n_i=0 | wr_n_i=0).
  - "First cycle" = mq true now and registered mq_d was 0.
  - All register updates happen only on a first cycle, so a held strobe updates exactly once.
- Qualified IO write (iw): iorq_n_i=0 & mreq_n_i=1 & wr_n_i=0; first-cycle detection identical to mq.
- Page selection (combinational):
  - LINEAR: 8000-BFFF -> 0; C000-FFFF -> 1 & mask; other addresses -> 0.
  - MEGACART: 8000-BFFF -> mask (last page); C000-FFFF -> megacart_pg; other -> 0.
  - SEGA: 0000-3FFF -> slot0; 4000-7FFF -> slot1; 8000-BFFF -> slot2; C000-FFFF -> 0.
- MEGACART register: first-cycle read (rd_n_i=0) with a_i[15:6]=0x3FF (FFC0-FFFF)
  - megacart_pg <= a_i[PAGE_W-1:0] & mask.
  - Writes to that window have no effect.
- SEGA registers: first-cycle write to FFFD/FFFE/FFFF
  - slot0/1/2 <= d_i[PAGE_W-1:0] & mask respectively.
  - FFFC is ignored.
- mapper_wr_o: 1 in the cycle after any bank-register load, otherwise 0.
  - Asserted even if the new value equals the old one.
- Registers of inactive modes hold their values; mode_i changes take effect combinationally. Software changes mode_i only under reset.
- SGM registers:
  - First-cycle iw to port a_i[7:0]=0x7F: bios_en_o <= d_i[1].
  - First-cycle iw to port 0x53: sgm_ram_en_o <= d_i[0] (if SGM_EN=1, else held 0).
  - In SEGA mode bios_en_o is forced to 0 every cycle.
- Wait generator:
  - Cartridge region is 8000-FFFF for LINEAR/MEGACART and 0000-BFFF for SEGA.
  - On first cycle of mq in the cartridge region with CART_WAIT>0: wait_n_o <= 0, counter <= CART_WAIT-1.
  - While the counter is non-zero, decrement each cycle. When it reaches 0, wait_n_o <= 1 on the next edge. Total low time is exactly CART_WAIT cycles.
  - Re-arm only after mq deasserts.
  - Reset mid-count: wait_n_o=1 and counter=0 on the reset edge.
- Simultaneous mq and iw in the same cycle is impossible on Z80; if it occurs, both are processed independently.
- Address/data bits beyond PAGE_W are ignored (masked). The mask is applied at load time, not at output.

Test Plan:
- Reset, mode 1, cart_pages_i=0x07, read FFC5 -> cart_page_o=5 at C123; 8000 -> 7; mapper_wr_o pulses once.
- Mode 1, hold read at FFC3 for 4 cycles, then read FFC9 -> single mapper_wr_o per access; megacart_pg=3, then 1.
- Mode 2, mask=0x0F, write 0x1A to FFFE -> slot1=0x0A; a_i=4000 gives rom_a_o=0x28000; slot0/2 unchanged (0/2).
- IO write 0x7F d=0x00 then 0x53 d=0x01 -> bios_en_o=0, sgm_ram_en_o=1. With SGM_EN=0 -> sgm_ram_en_o stays 0. Switch to mode 2 -> bios_en_o=0 while 0x7F d=0x02.
- CART_WAIT=3, read 8000 -> wait_n_o low exactly 3 cycles. Read 2000 in mode 0 -> no wait. Assert reset during count -> wait_n_o=1 on next edge.
- Reset mid-operation after loads -> all registers and outputs at the listed reset values.
